// File: rtl/linear_classifier_seq.sv
// Sequential linear classifier: one shared multiplier computes every class score
// one product per cycle, then reports the arg-max class and its score.
module linear_classifier_seq #(
  parameter int WIDTH     = 8,
  parameter int FEATURES  = 2,
  parameter int C_WIDTH   = 2,
  parameter int ACC_WIDTH = 20,
  parameter int SIGNED    = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [FEATURES*WIDTH-1:0]               features,
  input  logic [(2**C_WIDTH)*FEATURES*WIDTH-1:0]  weights,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [C_WIDTH-1:0]                      r_class,
  output logic [ACC_WIDTH-1:0]                    r_sum,
  output logic [WIDTH-1:0]                        r_value
);

  localparam int CLASSES = 2**C_WIDTH;
  localparam int FW      = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int EXT     = ACC_WIDTH - 2*WIDTH;

  localparam logic [FW-1:0]      LAST_F = FW'(FEATURES-1);
  localparam logic [C_WIDTH-1:0] LAST_C = C_WIDTH'(CLASSES-1);

  localparam logic [ACC_WIDTH-1:0] UMAX = {{(ACC_WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       feat_q [FEATURES];
  logic [WIDTH-1:0]       feat_d [FEATURES];
  logic [WIDTH-1:0]       wt_q   [CLASSES][FEATURES];
  logic [WIDTH-1:0]       wt_d   [CLASSES][FEATURES];
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   best_q, best_d;
  logic [C_WIDTH-1:0]     best_class_q, best_class_d;
  logic [C_WIDTH-1:0]     c_q, c_d;
  logic [FW-1:0]          f_q, f_d;
  logic [C_WIDTH-1:0]     r_class_q, r_class_d;
  logic [ACC_WIDTH-1:0]   r_sum_q, r_sum_d;
  logic [WIDTH-1:0]       r_value_q, r_value_d;

  logic [WIDTH-1:0]       feat_sel;
  logic [WIDTH-1:0]       wt_sel;
  logic [2*WIDTH-1:0]     prod;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   class_sum;
  logic                   sum_gt;
  logic                   take_best;
  logic [ACC_WIDTH-1:0]   best_new;
  logic [C_WIDTH-1:0]     best_class_new;

  // Clamp a full-width score into the WIDTH-bit result range.
  function automatic logic [WIDTH-1:0] sat_value(input logic [ACC_WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    if (SIGNED != 0) begin
      if ($signed(v) > $signed(SMAX)) begin
        res = SMAX[WIDTH-1:0];
      end else if ($signed(v) < $signed(SMIN)) begin
        res = SMIN[WIDTH-1:0];
      end else begin
        res = v[WIDTH-1:0];
      end
    end else begin
      if (v > UMAX) begin
        res = UMAX[WIDTH-1:0];
      end else begin
        res = v[WIDTH-1:0];
      end
    end
    return res;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r_class   = r_class_q;
  assign r_sum     = r_sum_q;
  assign r_value   = r_value_q;

  // Shared multiplier datapath and running best-class comparison.
  always_comb begin
    feat_sel = feat_q[f_q];
    wt_sel   = wt_q[c_q][f_q];
    if (SIGNED != 0) begin
      prod     = $signed({{WIDTH{feat_sel[WIDTH-1]}}, feat_sel})
               * $signed({{WIDTH{wt_sel[WIDTH-1]}}, wt_sel});
      prod_ext = {{EXT{prod[2*WIDTH-1]}}, prod};
      sum_gt   = $signed(acc_q + prod_ext) > $signed(best_q);
    end else begin
      prod     = {{WIDTH{1'b0}}, feat_sel} * {{WIDTH{1'b0}}, wt_sel};
      prod_ext = {{EXT{1'b0}}, prod};
      sum_gt   = (acc_q + prod_ext) > best_q;
    end
    class_sum = acc_q + prod_ext;
    // Class 0 seeds the best; later classes need a strict win so ties keep the lower index.
    take_best = (c_q == {C_WIDTH{1'b0}}) || sum_gt;
    if (take_best) begin
      best_new       = class_sum;
      best_class_new = c_q;
    end else begin
      best_new       = best_q;
      best_class_new = best_class_q;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    wt_d         = wt_q;
    acc_d        = acc_q;
    best_d       = best_q;
    best_class_d = best_class_q;
    c_d          = c_q;
    f_d          = f_q;
    r_class_d    = r_class_q;
    r_sum_d      = r_sum_q;
    r_value_d    = r_value_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int f = 0; f < FEATURES; f++) begin
            feat_d[f] = features[f*WIDTH +: WIDTH];
          end
          for (int c = 0; c < CLASSES; c++) begin
            for (int f = 0; f < FEATURES; f++) begin
              wt_d[c][f] = weights[(c*FEATURES+f)*WIDTH +: WIDTH];
            end
          end
          acc_d   = {ACC_WIDTH{1'b0}};
          c_d     = {C_WIDTH{1'b0}};
          f_d     = {FW{1'b0}};
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (f_q == LAST_F) begin
          best_d       = best_new;
          best_class_d = best_class_new;
          acc_d        = {ACC_WIDTH{1'b0}};
          f_d          = {FW{1'b0}};
          c_d          = c_q + C_WIDTH'(1);
          if (c_q == LAST_C) begin
            r_class_d = best_class_new;
            r_sum_d   = best_new;
            r_value_d = sat_value(best_new);
            state_d   = DONE;
          end else begin
            state_d = MAC;
          end
        end else begin
          acc_d = class_sum;
          f_d   = f_q + FW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= {ACC_WIDTH{1'b0}};
      best_q       <= {ACC_WIDTH{1'b0}};
      best_class_q <= {C_WIDTH{1'b0}};
      c_q          <= {C_WIDTH{1'b0}};
      f_q          <= {FW{1'b0}};
      r_class_q    <= {C_WIDTH{1'b0}};
      r_sum_q      <= {ACC_WIDTH{1'b0}};
      r_value_q    <= {WIDTH{1'b0}};
      for (int f = 0; f < FEATURES; f++) begin
        feat_q[f] <= {WIDTH{1'b0}};
      end
      for (int c = 0; c < CLASSES; c++) begin
        for (int f = 0; f < FEATURES; f++) begin
          wt_q[c][f] <= {WIDTH{1'b0}};
        end
      end
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      best_class_q <= best_class_d;
      c_q          <= c_d;
      f_q          <= f_d;
      r_class_q    <= r_class_d;
      r_sum_q      <= r_sum_d;
      r_value_q    <= r_value_d;
      feat_q       <= feat_d;
      wt_q         <= wt_d;
    end
  end

endmodule

// File: doc/linear_classifier_seq.md
Name: linear_classifier_seq

Overview:
Sequential, parametrised successor of the combinational linear classifier. It accepts one feature vector and one weight matrix per transaction through a valid/ready handshake. It computes every class score with a single shared multiplier, one product per cycle, and returns the arg-max class with a full-width score and a saturated WIDTH-bit score. It sits between the feature-extraction stage and the decision logic, and supports both unsigned and two's-complement operation.

Parameters:
WIDTH, 8, bit width of each feature and each weight
FEATURES, 2, number of features per vector (>=1)
C_WIDTH, 2, class index width; CLASSES = 2**C_WIDTH
ACC_WIDTH, 20, accumulator/score width; must be >= 2*WIDTH + clog2(FEATURES)
SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and scores

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  features/weights valid
in_ready  output  1  block can accept a transaction
features  input  FEATURES*WIDTH  feature f at bits [f*WIDTH +: WIDTH]
weights  input  CLASSES*FEATURES*WIDTH  weight (c,f) at bits [(c*FEATURES+f)*WIDTH +: WIDTH]
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
r_class  output  C_WIDTH  winning class index
r_sum  output  ACC_WIDTH  winning class score, full width
r_value  output  WIDTH  winning score saturated to WIDTH

Behaviour:
- Interface: one clock clk; synchronous active-high reset rst.
- Reset: state IDLE; in_ready=1; out_valid=0; r_class=0, r_sum=0, r_value=0; all internal registers cleared.
- States: IDLE, MAC, DONE.
- in_ready = (state==IDLE); it is combinational from state only and never depends on in_valid.
- IDLE: on an edge with in_valid&&in_ready, register features and weights, clear the accumulator, set c=0 and f=0, and go to MAC. While busy, in_valid is ignored and input buses may change freely.
- MAC, one product per edge: acc += feature[f]*weight[c][f].
  - Products and sums are sign-extended when SIGNED=1 and zero-extended otherwise, to ACC_WIDTH. No overflow is possible under the width rule.
  - On the edge with f==FEATURES-1, compare the class total against the best so far. Class 0 always loads the best. Class c>0 replaces it only if strictly greater (signed compare when SIGNED=1). Equal scores therefore keep the lowest index.
  - On that same edge, clear acc, set f=0 and increment c. Otherwise increment f.
  - After the last product of class CLASSES-1, go to DONE.
- Latency: with N = CLASSES*FEATURES and the accept edge at T, out_valid is first high after edge T+N.
- DONE: out_valid=1, and r_class, r_sum, r_value are stable. They hold unchanged while out_ready=0.
  - On an edge with out_valid&&out_ready, go to IDLE. out_valid drops and in_ready rises in the next cycle.
  - Outputs keep their last values after the handshake; only out_valid qualifies them.
  - Throughput: one transaction per N+2 cycles minimum.
- Saturation of r_value from the best score:
  - Unsigned: values > 2**WIDTH-1 give all-ones.
  - Signed: clamp to [-2**(WIDTH-1), 2**(WIDTH-1)-1].
  - Otherwise r_value is the low WIDTH bits.
- Reset mid-operation: rst has priority over all other conditions in any state. The current transaction is discarded with no output produced, and the block returns to the reset values.
- A zero vector or zero weights gives score 0 and class 0.

Test Plan:
- Default params, features (10,5), weights c0(1,2) c1(3,4) c2(2,1) c3(1,1), out_ready=1 -> class sums 20,50,25,15. out_valid is first high after edge T+8 with r_class=1, r_sum=50, r_value=50.
- Features (8,12), weights c0(5,2) c1(1,1) c2(2,3) c3(0,5) -> sums 64,20,52,60. Result r_class=0, r_sum=64.
- Tie case: features (5,5), weights c0(2,4) c1(3,3) c2(4,2) c3(3,3) -> all sums 30. Result r_class=0, r_value=30 (lowest index wins).
- Saturation: features (200,200), weights c0(255,255), all other weights 0 -> r_class=0, r_sum=102000, r_value=255.
- SIGNED=1: features (-3,4), weights c0(1,1) c1(-2,0) c2(0,-1) c3(-1,-1) -> sums 1,6,-4,-1. Result r_class=1, r_sum=6, r_value=6.
- Control:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0.
  - Pulse in_valid with new data during MAC -> it is ignored and the result is unchanged.
  - Assert rst for one cycle at MAC step 3 -> next cycle in_ready=1 and out_valid=0, and a new transaction then completes correctly.
